// File: rtl/sa_col_collector.sv
// Systolic-array output collector: de-skews per-column partial sums through small FIFOs,
// applies ReLU / arithmetic shift / int8 saturation and hands packed rows out over valid/ready.
module sa_col_collector #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic            COL_clk,
  input  logic            COL_rst,
  input  logic            COL_start,
  input  logic [15:0]     COL_rows,
  input  logic [4:0]      COL_shift,
  input  logic            COL_relu_en,
  input  logic [N-1:0]    COL_en_in,
  input  logic [N*32-1:0] COL_data_in,
  output logic            COL_out_valid,
  input  logic            COL_out_ready,
  output logic [N*8-1:0]  COL_out_data,
  output logic            COL_busy,
  output logic            COL_done,
  output logic            COL_overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e           state_q;
  logic [15:0]      rows_cfg_q;
  logic [15:0]      pop_cnt_q;
  logic [15:0]      emit_cnt_q;
  logic [4:0]       shift_q;
  logic             relu_q;
  logic             out_valid_q;
  logic [N*8-1:0]   out_data_q;
  logic             overflow_q;

  logic             run;
  logic             pop;
  logic             hs;
  logic [N-1:0]     nonempty;
  logic [N-1:0]     drop;
  logic [N*8-1:0]   row_d;

  function automatic logic [7:0] sat8(input logic signed [31:0] x,
                                      input logic [4:0] sh,
                                      input logic relu);
    logic signed [31:0] xr;
    logic signed [31:0] y;
    xr = (relu && x[31]) ? 32'sd0 : x;
    y  = xr >>> sh;
    if (y > 32'sd127)
      return 8'h7F;
    else if (y < -32'sd128)
      return 8'h80;
    else
      return y[7:0];
  endfunction

  // A start cycle flushes everything, so it must neither push nor pop.
  assign run = (state_q == ST_RUN) && !COL_start;
  assign hs  = out_valid_q && COL_out_ready;
  assign pop = run && (&nonempty) && (pop_cnt_q < rows_cfg_q) &&
               (!out_valid_q || COL_out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_col
      logic [31:0] mem [DEPTH];
      logic [AW:0] wr_ptr_q;
      logic [AW:0] rd_ptr_q;
      logic        full;
      logic        push;

      assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      assign nonempty[gi] = (wr_ptr_q != rd_ptr_q);
      // A full FIFO still accepts a write when the row pop frees a slot on the same edge.
      assign push         = run && COL_en_in[gi] && (!full || pop);
      assign drop[gi]     = run && COL_en_in[gi] && full && !pop;
      assign row_d[8*gi +: 8] = sat8(mem[rd_ptr_q[AW-1:0]], shift_q, relu_q);

      always_ff @(posedge COL_clk) begin
        if (push)
          mem[wr_ptr_q[AW-1:0]] <= COL_data_in[32*gi +: 32];
      end

      always_ff @(posedge COL_clk or posedge COL_rst) begin
        if (COL_rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else if (COL_start) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge COL_clk or posedge COL_rst) begin
    if (COL_rst) begin
      state_q     <= ST_IDLE;
      rows_cfg_q  <= '0;
      pop_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else if (COL_start) begin
      state_q     <= ST_RUN;
      rows_cfg_q  <= COL_rows;
      shift_q     <= COL_shift;
      relu_q      <= COL_relu_en;
      pop_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_RUN: begin
          if (pop) begin
            pop_cnt_q   <= pop_cnt_q + 16'd1;
            out_data_q  <= row_d;
            out_valid_q <= 1'b1;
          end else if (hs) begin
            out_valid_q <= 1'b0;
          end
          if (hs)
            emit_cnt_q <= emit_cnt_q + 16'd1;
          if (|drop)
            overflow_q <= 1'b1;
          if ((rows_cfg_q == 16'd0) || (hs && (emit_cnt_q + 16'd1 == rows_cfg_q)))
            state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign COL_out_valid = out_valid_q;
  assign COL_out_data  = out_data_q;
  assign COL_busy      = (state_q == ST_RUN);
  assign COL_done      = (state_q == ST_DONE);
  assign COL_overflow  = overflow_q;

endmodule

// File: tb/tb_sa_col_collector.sv
// Directed bench for sa_col_collector: table of single-row arithmetic vectors plus
// hand-written sequences for backpressure, overflow, restart, reset and idle behaviour.
module tb_sa_col_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  rows = '0;
  logic [4:0]   shift = '0;
  logic         relu = 1'b0;
  logic [3:0]   en = '0;
  logic [127:0] din = '0;
  logic         valid;
  logic         ready = 1'b0;
  logic [31:0]  dout;
  logic         busy;
  logic         done;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  sa_col_collector #(.N(4), .DEPTH(8)) dut (
    .COL_clk(clk), .COL_rst(rst), .COL_start(start), .COL_rows(rows),
    .COL_shift(shift), .COL_relu_en(relu), .COL_en_in(en), .COL_data_in(din),
    .COL_out_valid(valid), .COL_out_ready(ready), .COL_out_data(dout),
    .COL_busy(busy), .COL_done(done), .COL_overflow(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [4:0]   sh;
    logic         relu;
    logic [31:0]  exp;
  } vec_t;

  function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_cfg(input logic [15:0] r, input logic [4:0] sh, input logic rl);
    start = 1'b1; rows = r; shift = sh; relu = rl;
    tick();
    start = 1'b0;
  endtask

  task automatic push_skew(input logic [127:0] d);
    for (int c = 0; c < 4; c++) begin
      en = 4'b0001 << c;
      din = d;
      tick();
    end
    en = '0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{pk(10, -20, 30, -40),        5'd0,  1'b0, 32'hD81EEC0A};
    vecs[1] = '{pk(4096, -4096, 100, 2047),  5'd4,  1'b1, 32'h7F06007F};
    vecs[2] = '{pk(4096, -4096, 100, 2047),  5'd4,  1'b0, 32'h7F06807F};
    vecs[3] = '{pk(-1, -17, 127, -128),      5'd0,  1'b0, 32'h807FEFFF};
    vecs[4] = '{pk(-1, -17, 255, 128),       5'd1,  1'b0, 32'h407FF7FF};
    vecs[5] = '{pk(-300, 300, -257, 32'h7FFFFFFF), 5'd31, 1'b0, 32'h00FF00FF};
    vecs[6] = '{pk(-5, 5, -128, 128),        5'd0,  1'b1, 32'h7F000500};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_data", dout, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    #3 rst = 1'b0;
    tick();

    // Strobes while idle must not be captured
    en = 4'hF; din = pk(77, 77, 77, 77);
    repeat (3) tick();
    en = '0;
    chk("idle_valid", {31'd0, valid}, 0);
    chk("idle_ovf", {31'd0, ovf}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    $display("idle strobes: valid=%0b ovf=%0b", valid, ovf);

    // Single skewed rows from the vector table
    for (int v = 0; v < 7; v++) begin
      start_cfg(16'd1, vecs[v].sh, vecs[v].relu);
      chk("vec_busy", {31'd0, busy}, 1);
      push_skew(vecs[v].d);
      chk("vec_lat_valid0", {31'd0, valid}, 0);
      tick();
      chk("vec_valid", {31'd0, valid}, 1);
      chk("vec_data", dout, vecs[v].exp);
      $display("vector %0d: out=%h expect=%h", v, dout, vecs[v].exp);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("vec_done", {31'd0, done}, 1);
      chk("vec_valid_drop", {31'd0, valid}, 0);
      tick();
      chk("vec_done_pulse", {31'd0, done}, 0);
      chk("vec_idle", {31'd0, busy}, 0);
    end

    // Backpressure: three skewed rows, ready held low
    start_cfg(16'd3, 5'd0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      en = '0;
      for (int j = 0; j < 4; j++) begin
        if (t - j >= 0 && t - j < 3) begin
          en[j] = 1'b1;
          din[32*j +: 32] = 32'(10 * (t - j) + j + 1);
        end
      end
      tick();
    end
    en = '0;
    for (int h = 0; h < 5; h++) begin
      chk("bp_hold_valid", {31'd0, valid}, 1);
      chk("bp_hold_data", dout, 32'h04030201);
      chk("bp_ovf", {31'd0, ovf}, 0);
      tick();
    end
    ready = 1'b1;
    chk("bp_row0", dout, 32'h04030201);
    tick();
    chk("bp_row1_valid", {31'd0, valid}, 1);
    chk("bp_row1", dout, 32'h0E0D0C0B);
    tick();
    chk("bp_row2_valid", {31'd0, valid}, 1);
    chk("bp_row2", dout, 32'h18171615);
    chk("bp_no_early_done", {31'd0, done}, 0);
    tick();
    ready = 1'b0;
    chk("bp_end_valid", {31'd0, valid}, 0);
    chk("bp_done", {31'd0, done}, 1);
    tick();
    chk("bp_done_pulse", {31'd0, done}, 0);
    $display("backpressure: three rows drained");

    // Overflow on column 0
    start_cfg(16'd16, 5'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      en = 4'b0001;
      din = pk(k + 1, 0, 0, 0);
      tick();
      if (k == 7) chk("ovf_at_depth", {31'd0, ovf}, 0);
      if (k == 8) chk("ovf_after_depth1", {31'd0, ovf}, 1);
    end
    for (int k = 0; k < 8; k++) begin
      en = 4'b1110;
      din = pk(0, k + 20, k + 40, k + 60);
      tick();
    end
    en = '0;
    chk("ovf_valid", {31'd0, valid}, 1);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("ovf_drain_valid", {31'd0, valid}, 1);
      chk("ovf_drain_data", dout, {8'(k + 60), 8'(k + 40), 8'(k + 20), 8'(k + 1)});
      tick();
    end
    ready = 1'b0;
    chk("ovf_empty", {31'd0, valid}, 0);
    chk("ovf_sticky", {31'd0, ovf}, 1);
    chk("ovf_no_done", {31'd0, done}, 0);
    $display("overflow: ovf=%0b after drain", ovf);
    start_cfg(16'd0, 5'd0, 1'b0);
    chk("ovf_cleared", {31'd0, ovf}, 0);
    chk("rows0_busy", {31'd0, busy}, 1);
    chk("rows0_nodone", {31'd0, done}, 0);
    tick();
    chk("rows0_done", {31'd0, done}, 1);
    chk("rows0_novalid", {31'd0, valid}, 0);
    tick();
    chk("rows0_done_pulse", {31'd0, done}, 0);
    chk("rows0_idle", {31'd0, busy}, 0);

    // Restart with queued entries and a pending row
    start_cfg(16'd5, 5'd0, 1'b0);
    en = 4'hF; din = pk(85, 85, 85, 85);
    tick();
    en = 4'b0001;
    tick();
    tick();
    en = '0;
    tick();
    chk("rs_pending", {31'd0, valid}, 1);
    start = 1'b1; rows = 16'd1; en = 4'hF; din = pk(102, 102, 102, 102);
    tick();
    start = 1'b0; en = '0;
    chk("rs_valid_clr", {31'd0, valid}, 0);
    chk("rs_data_clr", dout, 0);
    chk("rs_busy", {31'd0, busy}, 1);
    en = 4'hF; din = pk(1, 2, 3, 4);
    tick();
    en = '0;
    chk("rs_lat", {31'd0, valid}, 0);
    tick();
    chk("rs_valid", {31'd0, valid}, 1);
    chk("rs_data", dout, 32'h04030201);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rs_done", {31'd0, done}, 1);
    tick();
    $display("restart: flushed row=%h", 32'h04030201);

    // Asynchronous reset mid-row
    start_cfg(16'd2, 5'd0, 1'b0);
    en = 4'hF; din = pk(9, 9, 9, 9);
    tick();
    en = '0;
    tick();
    chk("ar_pre_valid", {31'd0, valid}, 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, valid}, 0);
    chk("ar_data", dout, 0);
    chk("ar_busy", {31'd0, busy}, 0);
    #2 rst = 1'b0;
    tick();
    chk("ar_idle_busy", {31'd0, busy}, 0);
    chk("ar_idle_done", {31'd0, done}, 0);
    en = 4'hF; din = pk(55, 55, 55, 55);
    tick();
    en = '0;
    start_cfg(16'd1, 5'd0, 1'b0);
    en = 4'hF; din = pk(7, 8, 9, 10);
    tick();
    en = '0;
    tick();
    chk("ar_after_valid", {31'd0, valid}, 1);
    chk("ar_after_data", dout, 32'h0A090807);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ar_after_done", {31'd0, done}, 1);
    $display("reset recovery: row=%h", dout);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
